nibble_serial_alu: RTL and testbench

Sequential wrapper that performs WIDTH-bit ADD/AND/OR/XOR by driving one internal 4-bit ALU instance for one nibble per cycle. Carry is chained from nibble to nibble, least significant nibble first. The block sits between an operand source that uses a start/busy handshake and a consumer that samples the result on a one-cycle `done` pulse. It reuses the existing 4-bit ALU as its datapath instead of building a wide combinational adder.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/myALU.sv | 43 ++++
 rtl/nibble_serial_alu.sv | 164 ++++++++++++++++
 tb/tb_nibble_serial_alu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the nibble-serial ALU: operation mode,
//               sequencer state encoding and the nibble width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operation select shared by the 4-bit ALU and the serial wrapper.
  typedef enum logic [1:0] {
    ADD = 2'b00,
    AND = 2'b01,
    OR  = 2'b10,
    XOR = 2'b11
  } mode;

  // Sequencer states of the serial wrapper.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of one datapath slice.
  localparam int c_NIBBLE_W = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/myALU.sv
`default_nettype none
// ============================================================================
// Module      : myALU
// Description : 4-bit ALU (ADD/AND/OR/XOR) with carry-out and signed
//               overflow; carry and overflow are zero for logic ops.
// Revision    : 1.1 - mode type now taken from alu_pkg
// ============================================================================
module myALU
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cIn,
  input  mode        fn,
  output logic [3:0] result,
  output logic       cOut,
  output logic       V
);

  logic [4:0] w_sum;

  // Combinational slice: compute the selected operation on one nibble.
  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b} + {4'd0, cIn};
    result = 4'd0;
    cOut   = 1'b0;
    V      = 1'b0;
    case (fn)
      ADD: begin
        result = w_sum[3:0];
        cOut   = w_sum[4];
        // Overflow when both operands share a sign the sum does not.
        V      = (a[3] == b[3]) && (w_sum[3] != a[3]);
      end
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      default: result = 4'd0;
    endcase
  end

endmodule : myALU
`default_nettype wire

// File: rtl/nibble_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_alu
// Description : WIDTH-bit ADD/AND/OR/XOR computed one nibble per cycle on a
//               single 4-bit ALU, LSB nibble first, with start/busy/done
//               handshake and registered result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cOut,
  output logic             N,
  output logic             Z,
  output logic             V
);

  localparam int c_NIB   = WIDTH / c_NIBBLE_W;
  localparam int c_CNT_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NIB - 1);

  // Reject widths that cannot be split into whole nibbles.
  generate
    if (((WIDTH % c_NIBBLE_W) != 0) || (WIDTH < c_NIBBLE_W)) begin : g_bad_width
      $error("nibble_serial_alu: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  mode                r_fn;
  logic               r_carry;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
  logic               r_n;
  logic               r_z;
  logic               r_v;

  logic [3:0]         w_alu_res;
  logic               w_alu_cout;
  logic               w_alu_v;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_nxt;

  myALU u_alu (
    .a      (r_a[3:0]),
    .b      (r_b[3:0]),
    .cIn    (r_carry),
    .fn     (r_fn),
    .result (w_alu_res),
    .cOut   (w_alu_cout),
    .V      (w_alu_v)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NIB cycles, DONE for one.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        w_last = (r_cnt == c_LAST);
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result shifts right by a nibble with the new ALU nibble entering on top.
  always_comb begin
    w_res_nxt = r_result >> c_NIBBLE_W;
    w_res_nxt[WIDTH-1 -: c_NIBBLE_W] = w_alu_res;
  end

  // Datapath: operand capture, nibble shifting, carry chain and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_fn     <= ADD;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_fn     <= mode'(fn);
            r_carry  <= (mode'(fn) == ADD) ? cIn : 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          r_result <= w_res_nxt;
          r_a      <= r_a >> c_NIBBLE_W;
          r_b      <= r_b >> c_NIBBLE_W;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          if (r_fn == ADD) r_carry <= w_alu_cout;
          if (w_last) begin
            r_cout <= (r_fn == ADD) ? w_alu_cout : 1'b0;
            r_v    <= (r_fn == ADD) ? w_alu_v    : 1'b0;
          end
        end
        DONE: begin
          // Result is complete here; publish sign/zero with the done pulse.
          r_n    <= r_result[WIDTH-1];
          r_z    <= (r_result == '0);
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cOut   = r_cout;
  assign N      = r_n;
  assign Z      = r_z;
  assign V      = r_v;

endmodule : nibble_serial_alu
`default_nettype wire

// File: tb/tb_nibble_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_alu
// Description : Directed self-checking bench for nibble_serial_alu at
//               WIDTH=16, 8 and 4 driven in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cin;
  logic [1:0]  fn;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;

  logic        busy16, done16, cout16, n16, z16, v16;
  logic [15:0] res16;
  logic        busy8, done8, cout8, n8, z8, v8;
  logic [7:0]  res8;
  logic        busy4, done4, cout4, n4, z4, v4;
  logic [3:0]  res4;

  int n_total = 0;
  int n_bad   = 0;

  // Captured {V,Z,N,cOut,result} at the first done pulse of each DUT.
  logic [19:0] cap16;
  logic [11:0] cap8;
  logic [7:0]  cap4;
  int          lat16, lat8, lat4, cnt16, cnt8, cnt4;
  logic        bsy16;

  nibble_serial_alu #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .fn(fn), .a(a16), .b(b16), .cIn(cin),
    .busy(busy16), .done(done16), .result(res16), .cOut(cout16), .N(n16), .Z(z16), .V(v16));

  nibble_serial_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .fn(fn), .a(a8), .b(b8), .cIn(cin),
    .busy(busy8), .done(done8), .result(res8), .cOut(cout8), .N(n8), .Z(z8), .V(v8));

  nibble_serial_alu #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .fn(fn), .a(a4), .b(b4), .cIn(cin),
    .busy(busy4), .done(done4), .result(res4), .cOut(cout4), .N(n4), .Z(z4), .V(v4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Wide reference: returns {V,Z,N,cOut,result[15:0]} for a w-bit operation.
  function automatic logic [19:0] model(input int w, input logic [1:0] f,
                                        input logic [15:0] av, input logic [15:0] bv,
                                        input logic c);
    logic [16:0] s, mask17;
    logic [15:0] mask, x, y, r;
    logic        co, v, n, z;
    mask17 = (17'd1 << w) - 17'd1;
    mask   = mask17[15:0];
    x = av & mask;
    y = bv & mask;
    co = 1'b0;
    v  = 1'b0;
    case (f)
      2'b00: begin
        s  = {1'b0, x} + {1'b0, y} + {16'd0, c};
        r  = s[15:0] & mask;
        co = s[w];
        v  = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      end
      2'b01:   r = x & y;
      2'b10:   r = x | y;
      default: r = x ^ y;
    endcase
    n = r[w-1];
    z = (r == 16'd0);
    return {v, z, n, co, r};
  endfunction

  // Launch one op on all three DUTs (called at a negedge), scramble the
  // inputs after acceptance, then check latency, pulse count and results.
  task automatic run_op(input logic [1:0] f, input logic [15:0] av, input logic [15:0] bv,
                        input logic c);
    logic [19:0] m;
    fn = f; cin = c;
    a16 = av; b16 = bv; a8 = av[7:0]; b8 = bv[7:0]; a4 = av[3:0]; b4 = bv[3:0];
    start = 1'b1;
    lat16 = -1; lat8 = -1; lat4 = -1; cnt16 = 0; cnt8 = 0; cnt4 = 0; bsy16 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy16), 32'd1);
    a16 = ~av; b16 = ~bv; a8 = ~av[7:0]; b8 = ~bv[7:0]; a4 = ~av[3:0]; b4 = ~bv[3:0];
    fn = ~f; cin = ~c;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (done16) begin
        cnt16++;
        if (lat16 < 0) begin lat16 = e; cap16 = {v16, z16, n16, cout16, res16}; bsy16 = busy16; end
      end
      if (done8) begin
        cnt8++;
        if (lat8 < 0) begin lat8 = e; cap8 = {v8, z8, n8, cout8, res8}; end
      end
      if (done4) begin
        cnt4++;
        if (lat4 < 0) begin lat4 = e; cap4 = {v4, z4, n4, cout4, res4}; end
      end
    end
    chk("latency16", lat16, 5);
    chk("latency8",  lat8,  3);
    chk("latency4",  lat4,  2);
    chk("pulses16", cnt16, 1);
    chk("pulses8",  cnt8,  1);
    chk("pulses4",  cnt4,  1);
    chk("busy_at_done16", 32'(bsy16), 32'd0);
    m = model(16, f, av, bv, c);
    chk("res16",   32'(cap16[15:0]),  32'(m[15:0]));
    chk("flags16", 32'(cap16[19:16]), 32'(m[19:16]));
    m = model(8, f, av, bv, c);
    chk("res8",    32'(cap8[7:0]),    32'(m[7:0]));
    chk("flags8",  32'(cap8[11:8]),   32'(m[19:16]));
    m = model(4, f, av, bv, c);
    chk("res4",    32'(cap4[3:0]),    32'(m[3:0]));
    chk("flags4",  32'(cap4[7:4]),    32'(m[19:16]));
    @(negedge clk);
  endtask

  int          first, second, cntd;
  logic [15:0] r1, r2;

  initial begin
    rst_n = 1'b0; start = 1'b0; fn = 2'b00; cin = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy16), 32'd0);
    chk("rst_done",  32'(done16), 32'd0);
    chk("rst_res",   32'(res16),  32'd0);
    chk("rst_flags", 32'({v16, z16, n16, cout16}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=16 vectors with hand-computed results ({V,Z,N,cOut}).
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0);
    chk("add_ovf_res",   32'(cap16[15:0]),  32'h8000);
    chk("add_ovf_flags", 32'(cap16[19:16]), 32'b1010);
    run_op(2'b00, 16'hFFFF, 16'h0000, 1'b1);
    chk("add_wrap_res",   32'(cap16[15:0]),  32'h0000);
    chk("add_wrap_flags", 32'(cap16[19:16]), 32'b0101);
    run_op(2'b01, 16'hF0F0, 16'h0FF0, 1'b1);
    chk("and_res",   32'(cap16[15:0]),  32'h00F0);
    chk("and_flags", 32'(cap16[19:16]), 32'b0000);
    run_op(2'b10, 16'hF0F0, 16'h0FF0, 1'b0);
    chk("or_res",   32'(cap16[15:0]),  32'hFFF0);
    chk("or_flags", 32'(cap16[19:16]), 32'b0010);
    run_op(2'b11, 16'h1234, 16'h1234, 1'b0);
    chk("xor_res",   32'(cap16[15:0]),  32'h0000);
    chk("xor_flags", 32'(cap16[19:16]), 32'b0100);

    // Random operations on all widths against the reference.
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      run_op(2'b00, 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // start held high; operands change after the first acceptance.
    fn = 2'b00; cin = 1'b0; a16 = 16'h0003; b16 = 16'h0004; start = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h1000; b16 = 16'h0200;
    first = -1; second = -1; r1 = '0; r2 = '0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (done16) begin
        if (first < 0) begin first = e; r1 = res16; end
        else if (second < 0) begin second = e; r2 = res16; end
      end
    end
    start = 1'b0;
    chk("held_first_edge",  first,  5);
    chk("held_second_edge", second, 11);
    chk("held_gap", second - first, 6);
    chk("held_res1", 32'(r1), 32'h0007);
    chk("held_res2", 32'(r2), 32'h1200);
    repeat (12) @(posedge clk);
    @(negedge clk);

    // Reset asserted so it is sampled at the second RUN edge.
    fn = 2'b00; cin = 1'b0; a16 = 16'h1111; b16 = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy",  32'(busy16), 32'd0);
    chk("midrst_done",  32'(done16), 32'd0);
    chk("midrst_res",   32'(res16),  32'd0);
    chk("midrst_flags", 32'({v16, z16, n16, cout16}), 32'd0);
    rst_n = 1'b1;
    cntd = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done16) cntd++;
    end
    chk("midrst_no_done", cntd, 0);
    @(negedge clk);
    run_op(2'b00, 16'h1111, 16'h2222, 1'b0);
    chk("after_rst_res", 32'(cap16[15:0]), 32'h3333);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_nibble_serial_alu
`default_nettype wire
